// File: rtl/reel_renderer.sv
// rtl/reel_renderer.sv - reel window renderer: frame-synchronous symbol commit and 3-stage sprite lookup
// Optional REEL_BORDER_EN adds a 2 px 12'hFC0 border around each reel window.
module reel_renderer #(
    parameter logic [9:0]  REEL_X0     = 10'd192,
    parameter logic [9:0]  REEL_PITCH  = 10'd96,
    parameter logic [9:0]  WIN_Y0      = 10'd152,
    parameter logic [9:0]  WIN_H       = 10'd176,
    parameter logic [10:0] STRIP_OFS   = 11'd120,
    parameter logic [11:0] REEL_BG     = 12'h222,
    parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [8:0]  symbols,
    input  logic [47:0] symbols_y_coords,
    input  logic        symbols_valid,
    input  logic        frame_start,
    input  logic        video_on,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    output logic [14:0] rom_addr,
    input  logic [11:0] rom_data,
    output logic [11:0] rgb,
    output logic        rgb_hit
);

    logic [2:0]  in_sym   [3];
    logic [15:0] in_y     [3];
    logic [2:0]  pend_sym [3];
    logic [15:0] pend_y   [3];
    logic [2:0]  act_sym  [3];
    logic [15:0] act_y    [3];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            in_sym[i] = symbols[3*i +: 3];
            in_y[i]   = symbols_y_coords[16*i +: 16];
        end
    end

    // A strobe coinciding with frame_start bypasses pending straight into active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                pend_sym[i] <= 3'd0;
                pend_y[i]   <= 16'd176;
                act_sym[i]  <= 3'd0;
                act_y[i]    <= 16'd176;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (symbols_valid) begin
                    pend_sym[i] <= in_sym[i];
                    pend_y[i]   <= in_y[i];
                end
                if (frame_start) begin
                    act_sym[i] <= symbols_valid ? in_sym[i] : pend_sym[i];
                    act_y[i]   <= symbols_valid ? in_y[i]   : pend_y[i];
                end
            end
        end
    end

    logic [10:0] s_row;
    logic [10:0] left;
    logic        y_in;
    logic        in_win_c;
    logic        hit_c;
    logic [14:0] addr_c;
    logic        border_c;

    assign s_row = {1'b0, pixel_y} - {1'b0, WIN_Y0} + STRIP_OFS;
    assign y_in  = ({1'b0, pixel_y} >= {1'b0, WIN_Y0}) &&
                   ({1'b0, pixel_y} <  {1'b0, WIN_Y0} + {1'b0, WIN_H});

    // Walk reels high to low so the lowest index wins if windows overlap.
    always_comb begin
        in_win_c = 1'b0;
        hit_c    = 1'b0;
        addr_c   = 15'd0;
        left     = 11'd0;
        for (int i = 2; i >= 0; i--) begin
            left = {1'b0, REEL_X0} + 11'(i) * {1'b0, REEL_PITCH};
            if (video_on && y_in && ({1'b0, pixel_x} >= left) &&
                ({1'b0, pixel_x} < left + 11'd64)) begin
                in_win_c = 1'b1;
                hit_c    = ({6'd0, s_row} >= {1'b0, act_y[i]}) &&
                           ({6'd0, s_row} <  {1'b0, act_y[i]} + 17'd64);
                addr_c   = {act_sym[i], s_row[5:0] - act_y[i][5:0],
                            pixel_x[5:0] - left[5:0]};
            end
        end
    end

`ifdef REEL_BORDER_EN
    logic [11:0] bleft;
    logic        by_in;

    assign by_in = ({2'b0, pixel_y} + 12'd2 >= {2'b0, WIN_Y0}) &&
                   ({2'b0, pixel_y} <  {2'b0, WIN_Y0} + {2'b0, WIN_H} + 12'd2);

    always_comb begin
        border_c = 1'b0;
        bleft    = 12'd0;
        for (int i = 0; i < 3; i++) begin
            bleft = {2'b0, REEL_X0} + 12'(i) * {2'b0, REEL_PITCH};
            if (({2'b0, pixel_x} + 12'd2 >= bleft) && ({2'b0, pixel_x} < bleft + 12'd66))
                border_c = video_on && by_in && !in_win_c;
        end
    end
`else
    assign border_c = 1'b0;
`endif

    logic in_win1, hit1, border1;
    logic in_win2, hit2, border2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_win1  <= 1'b0;
            hit1     <= 1'b0;
            border1  <= 1'b0;
            rom_addr <= 15'd0;
            in_win2  <= 1'b0;
            hit2     <= 1'b0;
            border2  <= 1'b0;
            rgb      <= 12'd0;
            rgb_hit  <= 1'b0;
        end else begin
            in_win1 <= in_win_c;
            hit1    <= in_win_c && hit_c;
            border1 <= border_c;
            if (in_win_c && hit_c)
                rom_addr <= addr_c;
            in_win2 <= in_win1;
            hit2    <= hit1;
            border2 <= border1;
            if (hit2) begin
                rgb     <= (rom_data == TRANSPARENT) ? REEL_BG : rom_data;
                rgb_hit <= 1'b1;
            end else if (in_win2) begin
                rgb     <= REEL_BG;
                rgb_hit <= 1'b1;
            end else if (border2) begin
                rgb     <= 12'hFC0;
                rgb_hit <= 1'b1;
            end else begin
                rgb     <= 12'd0;
                rgb_hit <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reel_renderer.sv
// tb/tb_reel_renderer.sv - scoreboard bench for reel_renderer
module tb_reel_renderer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  symbols = '0;
    logic [47:0] symbols_y_coords = '0;
    logic        symbols_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic        video_on = 1'b0;
    logic [9:0]  pixel_x = '0;
    logic [9:0]  pixel_y = '0;
    logic [14:0] rom_addr;
    logic [11:0] rom_data = '0;
    logic [11:0] rgb;
    logic        rgb_hit;

    reel_renderer dut (
        .clk(clk), .rst_n(rst_n), .symbols(symbols), .symbols_y_coords(symbols_y_coords),
        .symbols_valid(symbols_valid), .frame_start(frame_start), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .rom_addr(rom_addr), .rom_data(rom_data),
        .rgb(rgb), .rgb_hit(rgb_hit)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit mon_en = 0;

    bit          ov_en = 0;
    logic [14:0] ov_addr = '0;
    logic [11:0] ov_val = '0;

    function automatic logic [11:0] rom_fn(input logic [14:0] a);
        if (ov_en && a == ov_addr) return ov_val;
        return {1'b0, a[14:12], a[7:0]};
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    typedef struct {
        bit          achk;
        logic [14:0] addr;
        logic [11:0] rgb;
        logic        hit;
    } exp_t;
    exp_t q[$];

    logic [2:0] ms[3], ps[3];
    int         my[3], py[3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            ms[i] = 3'd0; ps[i] = 3'd0; my[i] = 176; py[i] = 176;
        end
    endtask

    function automatic exp_t model(input logic vo, input logic [9:0] x, input logic [9:0] y);
        exp_t e;
        int xi, yi, left, s, d, c;
        bit found;
        logic [11:0] t;
        e.achk = 0; e.addr = '0; e.rgb = 12'h000; e.hit = 0;
        xi = int'(x); yi = int'(y); found = 0;
        for (int i = 0; i < 3; i++) begin
            left = 192 + 96 * i;
            if (!found && vo && yi >= 152 && yi <= 327 && xi >= left && xi <= left + 63) begin
                found = 1; e.hit = 1; e.rgb = 12'h222;
                s = yi - 152 + 120;
                if (s >= my[i] && s < my[i] + 64) begin
                    d = s - my[i]; c = xi - left;
                    e.achk = 1;
                    e.addr = {ms[i], d[5:0], c[5:0]};
                    t = rom_fn(e.addr);
                    e.rgb = (t == 12'hF0F) ? 12'h222 : t;
                end
            end
        end
`ifdef REEL_BORDER_EN
        for (int i = 0; i < 3; i++) begin
            left = 192 + 96 * i;
            if (!found && vo && yi >= 150 && yi <= 329 && xi + 2 >= left && xi <= left + 65) begin
                found = 1; e.hit = 1; e.rgb = 12'hFC0;
            end
        end
`endif
        return e;
    endfunction

    task automatic step(input logic vo, input logic [9:0] x, input logic [9:0] y,
                        input logic fs, input logic sv, input logic [8:0] sy, input logic [47:0] yc);
        exp_t e;
        @(posedge clk);
        #1;
        video_on = vo; pixel_x = x; pixel_y = y;
        frame_start = fs; symbols_valid = sv; symbols = sy; symbols_y_coords = yc;
        e = model(vo, x, y);
        q.push_back(e);
        if (sv) for (int i = 0; i < 3; i++) begin
            ps[i] = sy[3*i +: 3]; py[i] = int'(yc[16*i +: 16]);
        end
        if (fs) for (int i = 0; i < 3; i++) begin
            ms[i] = ps[i]; my[i] = py[i];
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 9'd0, 48'd0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() >= 2 && q[q.size()-2].achk)
                chk("rom_addr", 32'(rom_addr), 32'(q[q.size()-2].addr));
            if (q.size() >= 4) begin
                exp_t e;
                e = q.pop_front();
                chk("rgb", 32'(rgb), 32'(e.rgb));
                chk("rgb_hit", 32'(rgb_hit), 32'(e.hit));
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_rgb", 32'(rgb), 32'd0);
        chk("rst_rgb_hit", 32'(rgb_hit), 32'd0);
        rst_n = 1'b1;
        mon_en = 1;

        step(1, 10'd224, 10'd210, 1, 0, 9'd0, 48'd0);
        idle(3);
        step(1, 10'd224, 10'd210, 0, 1, {3'd5, 3'd3, 3'd1}, {16'd0, 16'd0, 16'd176});
        step(1, 10'd224, 10'd210, 0, 0, 9'd0, 48'd0);
        step(0, 10'd0, 10'd0, 1, 0, 9'd0, 48'd0);
        step(1, 10'd224, 10'd210, 0, 0, 9'd0, 48'd0);
        idle(3);

        step(0, 10'd0, 10'd0, 1, 1, {3'd2, 3'd4, 3'd6}, {16'd176, 16'd176, 16'd200});
        step(1, 10'd192, 10'd232, 0, 0, 9'd0, 48'd0);
        idle(3);

        ov_en = 1; ov_addr = {3'd6, 6'd0, 6'd0}; ov_val = 12'hF0F;
        step(1, 10'd192, 10'd232, 0, 0, 9'd0, 48'd0);
        step(1, 10'd100, 10'd100, 0, 0, 9'd0, 48'd0);
        step(0, 10'd224, 10'd210, 0, 0, 9'd0, 48'd0);
        idle(3);
        ov_en = 0;

        step(0, 10'd0, 10'd0, 1, 1, {3'd0, 3'd0, 3'd2}, {16'd176, 16'd176, 16'd352});
        for (int yy = 152; yy <= 327; yy += 7) step(1, 10'd200, 10'(yy), 0, 0, 9'd0, 48'd0);
        step(1, 10'd255, 10'd327, 0, 0, 9'd0, 48'd0);
        step(1, 10'd256, 10'd327, 0, 0, 9'd0, 48'd0);
        step(1, 10'd288, 10'd152, 0, 0, 9'd0, 48'd0);
        step(1, 10'd351, 10'd151, 0, 0, 9'd0, 48'd0);
        step(1, 10'd447, 10'd328, 0, 0, 9'd0, 48'd0);
        idle(3);

        for (int n = 0; n < 200; n++) begin
            logic sv, fs;
            logic [8:0] sy;
            logic [47:0] yc;
            sv = ($urandom_range(0, 7) == 0);
            fs = ($urandom_range(0, 11) == 0);
            sy = 9'($urandom);
            yc = {16'($urandom_range(100, 330)), 16'($urandom_range(100, 330)),
                  16'($urandom_range(100, 330))};
            step(1'($urandom_range(0, 9) != 0), 10'($urandom_range(180, 460)),
                 10'($urandom_range(140, 340)), fs, sv, sy, yc);
        end
        idle(3);

        step(0, 10'd0, 10'd0, 1, 1, {3'd3, 3'd3, 3'd3}, {16'd200, 16'd200, 16'd150});
        ov_en = 1; ov_addr = {3'd3, 6'd28, 6'd32}; ov_val = 12'h123;
        step(1, 10'd224, 10'd210, 0, 0, 9'd0, 48'd0);
        idle(2);
        @(posedge clk);
        #2;
        mon_en = 0;
        chk("pre_rst_rgb", 32'(rgb), 32'h123);
        rst_n = 1'b0;
        #1;
        chk("async_rst_rgb", 32'(rgb), 32'd0);
        chk("async_rst_rgb_hit", 32'(rgb_hit), 32'd0);
        chk("async_rst_rom_addr", 32'(rom_addr), 32'd0);
        ov_en = 0;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        model_reset();
        mon_en = 1;
        step(1, 10'd224, 10'd210, 0, 0, 9'd0, 48'd0);
        step(1, 10'd300, 10'd300, 0, 0, 9'd0, 48'd0);
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reel_renderer.md
Name: reel_renderer

Overview:
- Consumer end of the reel engine's symbol update stream. Latches `symbols`, `symbols_y_coords` and the `symbols_valid` strobe into a pending shadow set.
- Commits the pending set to an active set only at frame boundaries, so the picture never tears mid-frame.
- Turns VGA pixel coordinates into sprite ROM lookups through a fixed 3-cycle pipeline.
- Sits between the reel engine, the VGA timing generator and the symbol sprite ROM. Its output feeds the top-level colour mux.

Parameters:
- REEL_X0, 10'd192: screen x of reel 0 left edge.
- REEL_PITCH, 10'd96: x distance between reel left edges. Must be >= 64.
- WIN_Y0, 10'd152: screen y of the reel window top.
- WIN_H, 10'd176: reel window height in screen rows.
- STRIP_OFS, 11'd120: strip row shown on window row 0.
- REEL_BG, 12'h222: colour for window pixels not covered by a symbol, or covered by a transparent texel.
- TRANSPARENT, 12'hF0F: ROM texel value treated as transparent.

Ports:
- clk, input, 1: pixel clock.
- rst_n, input, 1: asynchronous active-low reset.
- symbols, input, 9: {sym2, sym1, sym0}, 3 bits each.
- symbols_y_coords, input, 48: {y2, y1, y0}, 16 bits each; strip row of each symbol top.
- symbols_valid, input, 1: one-cycle strobe; symbols and y coords are valid in that cycle.
- frame_start, input, 1: one-cycle pulse at vblank start.
- video_on, input, 1: pixel_x/pixel_y are in the visible area.
- pixel_x, input, 10: current pixel column.
- pixel_y, input, 10: current pixel row.
- rom_addr, output, 15: {symbol[2:0], row[5:0], col[5:0]}; synchronous ROM, 1-cycle read latency.
- rom_data, input, 12: texel returned one cycle after rom_addr.
- rgb, output, 12: pixel colour, 3 cycles after pixel_x/pixel_y.
- rgb_hit, output, 1: rgb is reel content (inside a window). Aligned with rgb.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Pending and active y coords = 176; pending and active symbols = 0.
  - Pipeline registers = 0; rom_addr = 0; rgb = 0; rgb_hit = 0.
- Capture: on symbols_valid=1, pending set <= inputs. The strobe is never dropped; the last strobe before a commit wins.
- Commit: on frame_start=1, active set <= pending set.
  - If symbols_valid and frame_start are high in the same cycle, the active set takes the new input values directly (the bypass), and pending is updated too.
- Stage 1 (registered in cycle N+1 for coordinates presented in cycle N):
  - in_win = video_on and pixel_y in [WIN_Y0, WIN_Y0+WIN_H-1] and pixel_x in [REEL_X0+i*REEL_PITCH, +63] for some reel i in 0..2.
  - s = pixel_y - WIN_Y0 + STRIP_OFS, computed in 11 bits; only evaluated when in_win, so it cannot underflow.
  - hit_i = (s >= y_i) and (s < y_i + 64), compared at 17 bits so y = 352 + 64 does not wrap.
  - rom_addr = {sym_i, (s - y_i)[5:0], (pixel_x - left_i)[5:0]}.
  - If no reel hits, rom_addr holds its previous value.
  - If windows overlap (illegal parameters), the lowest reel index wins.
- Stage 2 (cycle N+2): in_win and hit flags are delayed one cycle to align with rom_data.
- Stage 3 (cycle N+3), rgb / rgb_hit:
  - Outside any window: rgb = 0, rgb_hit = 0.
  - Inside a window, no symbol hit: rgb = REEL_BG, rgb_hit = 1.
  - Symbol hit, rom_data == TRANSPARENT: rgb = REEL_BG, rgb_hit = 1.
  - Symbol hit, otherwise: rgb = rom_data, rgb_hit = 1.
- A y coord of 0 or >= 352 is legal and simply produces no hit in the visible window at the default parameters.
- Reset mid-frame clears everything immediately. The next frame renders the rest position (y = 176) with symbol 0 until a commit.

Optional Feature:
- Macro: REEL_BORDER_EN.
- Defined: pixels within 2 px outside each reel window (left/right columns -2..-1 and 64..65; rows WIN_Y0-2..WIN_Y0-1 and WIN_Y0+WIN_H..+1) output rgb = 12'hFC0 with rgb_hit = 1. Same 3-cycle latency; border takes priority over the outside-window colour.
- Undefined: no border logic; those pixels behave as outside-window (rgb = 0, rgb_hit = 0).

Test Plan:
- Reset, then frame_start with pixel (224, 210) -> rom_addr = {3'd0, 6'd2, 6'd32} one cycle later; rgb = rom_data three cycles after the pixel.
- symbols_valid with syms {5,3,1}, y {0,0,176}, no frame_start, then scan pixel (224, 210) -> still symbol 0 rendered. After frame_start -> rom_addr symbol field = 1.
- symbols_valid and frame_start in the same cycle with y0 = 200 -> next pixel (192, 232): s = 200 -> rom_addr row = 0, col = 0 (bypass works).
- ROM returns 12'hF0F for a hit pixel -> rgb = 12'h222, rgb_hit = 1. Pixel (100, 100) -> rgb = 0, rgb_hit = 0.
- video_on = 0 over a window pixel -> rgb = 0, rgb_hit = 0. y0 = 352 -> reel 0 column shows only REEL_BG.
- Assert rst_n low mid-line while rgb = 12'h123 -> rgb = 0 asynchronously, and active y returns to 176.
